adc_sample_packer: RTL



---
 rtl/adc_sample_packer.sv | 112 +++++++++++
 1 files changed

// File: rtl/adc_sample_packer.sv
`default_nettype none
// ============================================================================
// Module   : adc_sample_packer
// Purpose  : Packs a free-running stream of scaled ADC samples into
//            2*SAMPLE_WIDTH+1 bit words (two samples plus end-of-scan flag)
//            and pushes them into the downstream HK sample FIFO. The sample
//            stream cannot be back-pressured, so one finished word is held
//            across a FIFO stall; further completing samples are dropped and
//            counted (saturating) with a sticky overflow flag.
// Ports    : clk, rst (async, active-high)
//            pk_enable    - accept samples when high
//            pk_clear     - synchronous clear of all state and counters
//            sample_valid / sample_data / sample_last - incoming sample
//            fifo_full    - downstream FIFO full flag
//            fifo_push / fifo_data_in - push strobe and packed word to FIFO
//                           word layout: [top]=last, [2W-1:W]=second,
//                           [W-1:0]=first sample
//            drop_count   - dropped samples, saturating at all-ones
//            overflow     - sticky, set on first drop
// Revision : 1.0 - initial release
// ============================================================================
module adc_sample_packer #(
    parameter int                      SAMPLE_WIDTH = 16,
    parameter logic [SAMPLE_WIDTH-1:0] PAD_VALUE    = '0,
    parameter int                      CNT_WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pk_enable,
    input  logic                      pk_clear,
    input  logic                      sample_valid,
    input  logic [SAMPLE_WIDTH-1:0]   sample_data,
    input  logic                      sample_last,
    input  logic                      fifo_full,
    output logic                      fifo_push,
    output logic [2*SAMPLE_WIDTH:0]   fifo_data_in,
    output logic [CNT_WIDTH-1:0]      drop_count,
    output logic                      overflow
);

    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

    logic                     r_half_full;
    logic [SAMPLE_WIDTH-1:0]  r_lo;
    logic                     r_out_valid;
    logic [2*SAMPLE_WIDTH:0]  r_out_word;
    logic [CNT_WIDTH-1:0]     r_drop_count;
    logic                     r_overflow;

    logic                     w_accept;
    logic                     w_push;
    logic                     w_complete;
    logic                     w_out_free;
    logic [2*SAMPLE_WIDTH:0]  w_word;

    assign w_accept   = sample_valid & pk_enable & ~pk_clear;
    // A clear cycle never pushes: the word it discards must not reach the FIFO.
    assign w_push     = r_out_valid & ~fifo_full & ~pk_clear;
    // A lone last sample closes its word early with the pad in the upper half.
    assign w_complete = w_accept & (r_half_full | sample_last);
    // The holding register can take a new word while its current one leaves.
    assign w_out_free = ~r_out_valid | w_push;
    assign w_word     = r_half_full ? {sample_last, sample_data, r_lo}
                                    : {1'b1, PAD_VALUE, sample_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_half_full  <= 1'b0;
            r_lo         <= '0;
            r_out_valid  <= 1'b0;
            r_out_word   <= '0;
            r_drop_count <= '0;
            r_overflow   <= 1'b0;
        end else if (pk_clear) begin
            r_half_full  <= 1'b0;
            r_lo         <= '0;
            r_out_valid  <= 1'b0;
            r_out_word   <= '0;
            r_drop_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_push) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                if (!w_complete) begin
                    r_lo        <= sample_data;
                    r_half_full <= 1'b1;
                end else if (w_out_free) begin
                    r_out_word  <= w_word;
                    r_out_valid <= 1'b1;
                    r_half_full <= 1'b0;
                end else begin
                    // Dropped: lo_reg/half_full stay, so the held first
                    // sample pairs with the next accepted one.
                    r_overflow <= 1'b1;
                    if (r_drop_count != c_CNT_MAX) begin
                        r_drop_count <= r_drop_count + c_CNT_ONE;
                    end
                end
            end
        end
    end

    assign fifo_push    = w_push;
    assign fifo_data_in = r_out_word;
    assign drop_count   = r_drop_count;
    assign overflow     = r_overflow;

endmodule
`default_nettype wire
